rs_encoder: RTL and testbench
=============================

RS_ENCODER -- requirements
Module: rs_encoder

Interface
REQ-001 SHALL use compile-time constant `N, default 7: codeword length in symbols.
REQ-002 SHALL use compile-time constant `K, default 5: message length in symbols.
REQ-003 SHALL use compile-time constant `SYMBOL_WIDTH, default 3: bits per GF(8) symbol.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: in_symbol holds a message symbol.
REQ-008 SHALL have port in_ready, output, 1 bit: encoder accepts a symbol this cycle.
REQ-009 SHALL have port in_symbol, input, `SYMBOL_WIDTH bits: message symbol, highest-degree symbol first.
REQ-010 SHALL have port out_valid, output, 1 bit: codeword holds a complete codeword.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream decoder accepts the codeword.
REQ-012 SHALL have port codeword, output, `N*`SYMBOL_WIDTH bits: systematic codeword feeding RS_Decoder.codeword.

Function
REQ-013 SHALL implement GF(8) with primitive polynomial x^3+x+1; symbol bit 2 = alpha^0 coefficient, bit 1 = alpha^1, bit 0 = alpha^2 (alpha^0=100, alpha^1=010, alpha^2=001, alpha^3=110, alpha^4=011, alpha^5=111, alpha^6=101); addition is bitwise XOR.
REQ-014 SHALL use generator g(x) = (x+alpha)(x+alpha^2) = x^2 + g1*x + g0, with g1 = alpha^4 (011) and g0 = alpha^3 (110).
REQ-015 SHALL implement a two-stage LFSR (r1, r0); on each accepted symbol d: f = d^r1, r1 <= r0 ^ g1*f, r0 <= g0*f.
REQ-016 SHALL have two states: LOAD (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 SHALL accept a symbol only when in_valid && in_ready; a 3-bit counter cnt SHALL track accepted symbols 0..`K-1.
REQ-018 SHALL place the i-th accepted symbol (i=0..4) at codeword[20-3i -: 3].
REQ-019 SHALL, on acceptance of the symbol with cnt==`K-1, move to HOLD next cycle; codeword[5:3] = final r1 (parity p1), codeword[2:0] = final r0 (parity p0). Latency from the 5th accept to out_valid is one cycle.
REQ-020 SHALL hold codeword and out_valid stable in HOLD until out_ready is high; the transfer completes on a clk edge with out_valid && out_ready.
REQ-021 SHALL, on that transfer edge, return to LOAD with cnt, r1 and r0 cleared; no symbol is accepted in that cycle.
REQ-022 SHALL ignore in_symbol whenever in_valid is low; no stall limit on in_valid gaps between symbols.

Reset
REQ-023 SHALL, while reset is high, asynchronously set state=LOAD, cnt=0, r1=r0=0, codeword=0, out_valid=0, in_ready=1.
REQ-024 SHALL discard any partially loaded message when reset is asserted mid-message or in HOLD; the first accept after reset is symbol 0 of a new message.

Configuration
REQ-025 SHALL, when macro RS_ENC_ERR_INJECT_EN is defined, add port err_mask, input, `N*`SYMBOL_WIDTH bits, sampled on the 5th-symbol accept edge and XORed into the whole codeword latched for HOLD.
REQ-026 SHALL, when RS_ENC_ERR_INJECT_EN is undefined, omit err_mask and always output the uncorrupted codeword.

Verification
REQ-027 SHALL check: message 000,000,000,000,000 -> codeword 21'b0, out_valid one cycle after the 5th accept.
REQ-028 SHALL check: message 100,000,000,000,000 -> codeword 21'b100_000_000_000_000_011_010.
REQ-029 SHALL check: message 000,000,000,000,100 -> codeword 21'b000_000_000_000_100_011_110.
REQ-030 SHALL check: out_ready held low 10 cycles in HOLD, in_valid high -> in_ready=0, codeword and out_valid stable; release -> one transfer, then LOAD.
REQ-031 SHALL check: reset asserted after 3 accepts -> outputs cleared immediately; the next 5 symbols 100,000,000,000,000 -> codeword per REQ-028.
REQ-032 SHALL check, with RS_ENC_ERR_INJECT_EN: message per REQ-028, err_mask=21'h000001 -> codeword 21'b100_000_000_000_000_011_011.

Source files
------------

// File: rtl/rs_encoder.sv
// Systematic RS(7,5) encoder over GF(8) (x^3+x+1), valid/ready in, codeword out.
// Define RS_ENC_ERR_INJECT_EN to add the err_mask codeword-corruption port.
module rs_encoder #(
    parameter int N            = 7,
    parameter int K            = 5,
    parameter int SYMBOL_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SYMBOL_WIDTH-1:0]   in_symbol,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef RS_ENC_ERR_INJECT_EN
    input  logic [N*SYMBOL_WIDTH-1:0] err_mask,
`endif
    output logic [N*SYMBOL_WIDTH-1:0] codeword
);

    localparam int W     = SYMBOL_WIDTH;
    localparam int CWW   = N * W;
    localparam int MW    = K * W;
    localparam int CNT_W = 3;

    localparam logic [W-1:0] G1 = W'(3'b011);
    localparam logic [W-1:0] G0 = W'(3'b110);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Symbol bit 2 is the alpha^0 coefficient, so operands are bit-reversed
    // into polynomial order, multiplied, reduced and reversed back.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [2:0] pa;
        logic [2:0] pb;
        logic [4:0] prod;
        pa   = {a[0], a[1], a[2]};
        pb   = {b[0], b[1], b[2]};
        prod = '0;
        for (int i = 0; i < 3; i++) begin
            if (pb[i]) prod = prod ^ ({2'b00, pa} << i);
        end
        if (prod[4]) prod = prod ^ 5'b10110;
        if (prod[3]) prod = prod ^ 5'b01011;
        return {prod[0], prod[1], prod[2]};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     r1_q, r1_d;
    logic [W-1:0]     r0_q, r0_d;
    logic [MW-1:0]    msg_q, msg_d;
    logic [CWW-1:0]   cw_q, cw_d;
    logic             ovalid_q, ovalid_d;
    logic             iready_q, iready_d;

    logic             accept;
    logic [W-1:0]     fb;
    logic [W-1:0]     r1_nx;
    logic [W-1:0]     r0_nx;
    logic [CWW-1:0]   mask;

`ifdef RS_ENC_ERR_INJECT_EN
    assign mask = err_mask;
`else
    assign mask = '0;
`endif

    assign accept = in_valid && iready_q;
    assign fb     = in_symbol ^ r1_q;
    assign r1_nx  = r0_q ^ gf_mul(G1, fb);
    assign r0_nx  = gf_mul(G0, fb);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r1_d     = r1_q;
        r0_d     = r0_q;
        msg_d    = msg_q;
        cw_d     = cw_q;
        ovalid_d = ovalid_q;
        iready_d = iready_q;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    msg_d = {msg_q[MW-W-1:0], in_symbol};
                    r1_d  = r1_nx;
                    r0_d  = r0_nx;
                    if (cnt_q == LAST) begin
                        state_d  = HOLD;
                        cw_d     = {msg_q[MW-W-1:0], in_symbol,
                                    r1_nx, r0_nx} ^ mask;
                        ovalid_d = 1'b1;
                        iready_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    r1_d     = '0;
                    r0_d     = '0;
                    ovalid_d = 1'b0;
                    iready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            r1_q     <= '0;
            r0_q     <= '0;
            msg_q    <= '0;
            cw_q     <= '0;
            ovalid_q <= 1'b0;
            iready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r1_q     <= r1_d;
            r0_q     <= r0_d;
            msg_q    <= msg_d;
            cw_q     <= cw_d;
            ovalid_q <= ovalid_d;
            iready_q <= iready_d;
        end
    end

    assign codeword  = cw_q;
    assign out_valid = ovalid_q;
    assign in_ready  = iready_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: fixed vectors, handshake/reset corners, random vs model.
// Build with RS_ENC_ERR_INJECT_EN to exercise the err_mask path as well.
module tb_rs_encoder;

    localparam int K = 5;

`ifdef RS_ENC_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_symbol;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] err_mask;
    logic [20:0] codeword;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rs_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_symbol (in_symbol),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef RS_ENC_ERR_INJECT_EN
        .err_mask  (err_mask),
`endif
        .codeword  (codeword)
    );

    typedef struct {
        logic [14:0] msg;
        logic [20:0] mask;
        logic [20:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic logic [2:0] gexp(input int e);
        case (e % 7)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            3:       return 3'b110;
            4:       return 3'b011;
            5:       return 3'b111;
            default: return 3'b101;
        endcase
    endfunction

    function automatic int glog(input logic [2:0] s);
        for (int e = 0; e < 7; e++) begin
            if (gexp(e) == s) return e;
        end
        return 0;
    endfunction

    function automatic logic [2:0] gmul(input logic [2:0] a,
                                        input logic [2:0] b);
        if (a == 3'b000 || b == 3'b000) return 3'b000;
        return gexp(glog(a) + glog(b));
    endfunction

    // Remainder of m(x)*x^2 divided by g(x) by long division.
    function automatic logic [20:0] model(input logic [14:0] msg);
        logic [2:0] c [7];
        logic [2:0] coef;
        for (int i = 0; i < 7; i++) begin
            c[i] = (i < K) ? msg[14-3*i -: 3] : 3'b000;
        end
        for (int i = 0; i < K; i++) begin
            coef     = c[i];
            c[i + 1] = c[i + 1] ^ gmul(coef, 3'b011);
            c[i + 2] = c[i + 2] ^ gmul(coef, 3'b110);
        end
        return {msg, c[5], c[6]};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [20:0] act,
                        input logic [20:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %021b expected %021b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        chk1({name, "_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic load_msg(input logic [14:0] msg, input logic [20:0] mask,
                            input logic [20:0] exp, input int maxgap,
                            input string name);
        int gap;
        for (int i = 0; i < K; i++) begin
            gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
            repeat (gap) begin
                in_valid  = 1'b0;
                in_symbol = 3'($urandom);
                step();
            end
            in_valid  = 1'b1;
            in_symbol = msg[14-3*i -: 3];
            if (i == K - 1) err_mask = mask;
            wait_ready(name);
            if (i == K - 1) chk1({name, "_early_valid"}, out_valid, 1'b0);
            step();
        end
        in_valid  = 1'b0;
        in_symbol = 3'($urandom);
        err_mask  = 21'($urandom);
        chk1({name, "_out_valid"}, out_valid, 1'b1);
        chk1({name, "_busy"}, in_ready, 1'b0);
        chkw({name, "_codeword"}, codeword, exp);
    endtask

    task automatic drain(input logic [20:0] exp, input int hold,
                         input string name);
        for (int c = 0; c < hold; c++) begin
            in_valid  = 1'b1;
            in_symbol = 3'($urandom);
            step();
            chk1({name, "_hold_valid"}, out_valid, 1'b1);
            chk1({name, "_hold_ready"}, in_ready, 1'b0);
            chkw({name, "_hold_cw"}, codeword, exp);
        end
        // A symbol offered on the transfer cycle must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_symbol = 3'b111;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk1({name, "_post_valid"}, out_valid, 1'b0);
        chk1({name, "_post_ready"}, in_ready, 1'b1);
    endtask

    task automatic run_msg(input logic [14:0] msg, input logic [20:0] mask,
                           input logic [20:0] exp, input int maxgap,
                           input int hold, input string name);
        load_msg(msg, mask, exp, maxgap, name);
        drain(exp, hold, name);
    endtask

    task automatic check_reset_state(input string name);
        chk1({name, "_rst_valid"}, out_valid, 1'b0);
        chk1({name, "_rst_ready"}, in_ready, 1'b1);
        chkw({name, "_rst_cw"}, codeword, 21'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] m;
        logic [20:0] mk;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_symbol = 3'b000;
        out_ready = 1'b0;
        err_mask  = 21'b0;
        #3;
        check_reset_state("initial");
        step();
        step();
        reset = 1'b0;
        step();

        vt.push_back('{msg: 15'b0, mask: 21'b0, exp: 21'b0});
        vt.push_back('{msg: 15'b100_000_000_000_000, mask: 21'b0,
                       exp: 21'b100_000_000_000_000_011_010});
        vt.push_back('{msg: 15'b000_000_000_000_100, mask: 21'b0,
                       exp: 21'b000_000_000_000_100_011_110});
        vt.push_back('{msg: 15'b000_000_000_000_010, mask: 21'b0,
                       exp: 21'b000_000_000_000_010_111_011});
`ifdef RS_ENC_ERR_INJECT_EN
        vt.push_back('{msg: 15'b100_000_000_000_000, mask: 21'h000001,
                       exp: 21'b100_000_000_000_000_011_011});
`endif
        foreach (vt[i]) begin
            run_msg(vt[i].msg, vt[i].mask, vt[i].exp, 0, 0,
                    $sformatf("vec%0d", i));
        end

        // Long backpressure with in_valid held high.
        run_msg(15'b100_000_000_000_000, 21'b0,
                21'b100_000_000_000_000_011_010, 0, 10, "stall");

        // Reset after three accepts drops the partial message.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_symbol = 3'b101;
            step();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midmsg");
        step();
        reset = 1'b0;
        run_msg(15'b100_000_000_000_000, 21'b0,
                21'b100_000_000_000_000_011_010, 0, 0, "after_rst");

        // Reset while holding a codeword.
        load_msg(15'b011_101_110_001_111, 21'b0,
                 model(15'b011_101_110_001_111), 1, "pre_hold_rst");
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("hold");
        step();
        reset = 1'b0;
        run_msg(15'b000_000_000_000_100, 21'b0,
                21'b000_000_000_000_100_011_110, 0, 0, "after_hold_rst");

        for (int r = 0; r < 40; r++) begin
            m  = 15'($urandom);
            mk = INJ ? 21'($urandom) : 21'b0;
            run_msg(m, mk, model(m) ^ mk, 3, $urandom_range(3, 0),
                    $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
